// File: rtl/arb_pkg.sv
// Shared types and constants for the two-input round-robin stream arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2x1.sv
// Single-bit 2:1 select; s = 0 picks a, s = 1 picks b.
module mux_2x1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/stream_arb_2x1.sv
// Round-robin 2:1 stream arbiter: grant locks for a whole packet, priority
// alternates after each last beat, and the chosen beat lands in one output register.
//
// Handshake: a beat moves when valid && ready are both high on a rising edge.
// Sources must not make valid depend on ready. Here ready may depend on valid
// (IDLE tie-break) and on y_ready (output slot space); y_data never sees y_ready.
module stream_arb_2x1
  import arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_last,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic             pri;
  logic             pri_next;
  logic             grant_a;
  logic             grant_b;
  logic             space;
  logic             xfer_a;
  logic             xfer_b;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  assign space = !y_valid || y_ready;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    sel     = pri;
    case (state)
      IDLE: begin
        grant_a = a_valid && (!b_valid || pri == SEL_A);
        grant_b = b_valid && (!a_valid || pri == SEL_B);
        if (grant_a)      sel = SEL_A;
        else if (grant_b) sel = SEL_B;
      end
      LOCK_A: begin
        grant_a = 1'b1;
        sel     = SEL_A;
      end
      LOCK_B: begin
        grant_b = 1'b1;
        sel     = SEL_B;
      end
      default: ;
    endcase
  end

  assign a_ready = grant_a && space;
  assign b_ready = grant_b && space;
  assign xfer_a  = a_valid && a_ready;
  assign xfer_b  = b_valid && b_ready;
  assign busy    = (state != IDLE);

  // sel always points at the transferring source, so the muxes carry its beat.
  for (genvar i = 0; i < WIDTH; i++) begin : g_data_mux
    mux_2x1 u_mux (.a(a_data[i]), .b(b_data[i]), .s(sel), .y(mux_data[i]));
  end
  mux_2x1 u_last_mux (.a(a_last), .b(b_last), .s(sel), .y(mux_last));

  always_comb begin
    state_next = state;
    pri_next   = pri;
    if (xfer_a || xfer_b) begin
      if (mux_last) begin
        state_next = IDLE;
        pri_next   = xfer_b ? SEL_A : SEL_B;
      end else begin
        state_next = xfer_b ? LOCK_B : LOCK_A;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pri   <= SEL_A;
    end else begin
      state <= state_next;
      pri   <= pri_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
    end else if (xfer_a || xfer_b) begin
      y_valid <= 1'b1;
      y_data  <= mux_data;
      y_last  <= mux_last;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
